mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/arb_starve_ctr.sv | 32 +++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: response-owner states and the
// default fetch starvation limit.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        D_RD  = 2'd2
    } owner_e;

    localparam int unsigned STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Fetch starvation counter: counts consecutive fetch denials, saturates at
// STARVE_LIMIT and requests a forced fetch grant when the limit is reached.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic if_gnt,
    output logic force_fetch
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!if_req || if_gnt) begin
            cnt <= '0;
        end else if (cnt != LIM) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign force_fetch = if_req && (cnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch / data) for a single synchronous-read RAM port.
// Optional fetch fairness is enabled with the ARB_FAIRNESS_EN macro.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:2] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:2] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:2] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        if_stall,
    output logic        d_stall
);

    if (STARVE_LIMIT < 1) begin : g_limit_chk
        $error("STARVE_LIMIT must be at least 1");
    end

    owner_e      state;
    logic        force_fetch;
    logic [31:2] addr_q;
    logic [31:0] wdata_q;

`ifdef ARB_FAIRNESS_EN
    arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_gnt      (if_gnt),
        .force_fetch (force_fetch)
    );
`else
    assign force_fetch = 1'b0;
`endif

    // Grants are gated by reset so nothing reaches the RAM while held in reset.
    assign d_gnt    = reset && d_req && !force_fetch;
    assign if_gnt   = reset && if_req && (!d_req || force_fetch);
    assign if_stall = if_req && !if_gnt;
    assign d_stall  = d_req && !d_gnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (d_gnt) begin
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
        end else if (if_gnt) begin
            addr_q  <= if_addr;
        end
    end

    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_we    = d_we;
            mem_be    = d_be;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
            mem_be    = 4'hF;
        end
    end

    // Owner of the read data returning next cycle; writes leave no response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (if_gnt) begin
            state <= IF_RD;
        end else if (d_gnt && !d_we) begin
            state <= D_RD;
        end else begin
            state <= IDLE;
        end
    end

    assign if_rvalid = (state == IF_RD);
    assign d_rvalid  = (state == D_RD);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule
